// File: rtl/mm_bus_pkg.sv
// Shared definitions for the memory-mapped bus arbiter slice.
// State encodings, default widths and the lock timeout default.
package mm_bus_pkg;

   localparam int MM_ADDR_W_DEF   = 8;
   localparam int MM_DATA_W_DEF   = 16;
   localparam int NUM_MST_DEF     = 2;
   localparam int TIMEOUT_CYC_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_ACK  = 2'd2,
      ST_HOLD = 2'd3
   } arb_st_e;

endpackage

// File: rtl/mm_bus_arb_if.sv
// Master-side request/grant bundle plus the shared slave bus.
// The arbiter uses the master modport; masters and slave decode use slave.
interface mm_bus_arb_if
   import mm_bus_pkg::*;
#(
   parameter int NUM_MST       = NUM_MST_DEF,
   parameter int MM_ADDR_WIDTH = MM_ADDR_W_DEF,
   parameter int MM_DATA_WIDTH = MM_DATA_W_DEF
);

   logic [NUM_MST-1:0]               mst_req_i;
   logic [NUM_MST-1:0]               mst_lock_i;
   logic [NUM_MST-1:0]               mst_we_i;
   logic [NUM_MST*MM_ADDR_WIDTH-1:0] mst_addr_i;
   logic [NUM_MST*MM_DATA_WIDTH-1:0] mst_wdata_i;
   logic [NUM_MST-1:0]               mst_gnt_o;
   logic [NUM_MST-1:0]               mst_ack_o;
   logic [MM_DATA_WIDTH-1:0]         mst_rdata_o;
   logic [MM_ADDR_WIDTH-1:0]         mm_m_addr_o;
   logic [MM_DATA_WIDTH-1:0]         mm_m_wdata_o;
   logic                             mm_m_we_o;
   logic [MM_DATA_WIDTH-1:0]         mm_m_rdata_i;
   logic                             arb_tmo_o;

   modport master (
      input  mst_req_i, mst_lock_i, mst_we_i,
      input  mst_addr_i, mst_wdata_i, mm_m_rdata_i,
      output mst_gnt_o, mst_ack_o, mst_rdata_o,
      output mm_m_addr_o, mm_m_wdata_o, mm_m_we_o,
      output arb_tmo_o
   );

   modport slave (
      output mst_req_i, mst_lock_i, mst_we_i,
      output mst_addr_i, mst_wdata_i, mm_m_rdata_i,
      input  mst_gnt_o, mst_ack_o, mst_rdata_o,
      input  mm_m_addr_o, mm_m_wdata_o, mm_m_we_o,
      input  arb_tmo_o
   );

endinterface

// File: rtl/mm_arb_rr_pick.sv
// Combinational rotate-priority picker: first requester after last_gnt.
// last_gnt is one-hot; gnt is one-hot and valid only when vld is set.
module mm_arb_rr_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] last_gnt,
   output logic [N-1:0] gnt,
   output logic         vld
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] idx;
   int            base;

   always_comb begin
      gnt  = '0;
      vld  = 1'b0;
      base = 0;
      idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (last_gnt[i]) base = i;
      end
      // offset 1..N, so the last owner is considered last
      for (int k = 1; k <= N; k++) begin
         idx = IW'((base + k) % N);
         if (!vld && req[idx]) begin
            gnt[idx] = 1'b1;
            vld      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mm_bus_arb.sv
// Round-robin arbiter/sequencer for the shared memory-mapped slave bus.
// Optional lock-hold timeout enabled by defining MM_ARB_TIMEOUT_EN.
module mm_bus_arb
   import mm_bus_pkg::*;
#(
   parameter int MM_ADDR_WIDTH = MM_ADDR_W_DEF,
   parameter int MM_DATA_WIDTH = MM_DATA_W_DEF,
   parameter int NUM_MST       = NUM_MST_DEF,
   parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
   input  logic         clk_sys_i,
   input  logic         rst_n_i,
   mm_bus_arb_if.master bus
);

   localparam int AW = MM_ADDR_WIDTH;
   localparam int DW = MM_DATA_WIDTH;
   localparam int N  = NUM_MST;

   arb_st_e       st_q, st_d;
   logic [N-1:0]  gnt_q, last_q, win, sel;
   logic          win_vld;
   logic [AW-1:0] addr_q, sel_addr;
   logic [DW-1:0] wdata_q, sel_wdata, rdata_q;
   logic          we_q, sel_we;
   logic          load, drop, tmo_hit;
   logic          own_req, own_lock;

   mm_arb_rr_pick #(.N(N)) u_pick (
      .req      (bus.mst_req_i),
      .last_gnt (last_q),
      .gnt      (win),
      .vld      (win_vld)
   );

   assign own_req  = |(bus.mst_req_i & gnt_q);
   assign own_lock = |(bus.mst_lock_i & gnt_q);

   always_comb begin
      sel       = (st_q == ST_IDLE) ? win : gnt_q;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) begin
            sel_addr  = bus.mst_addr_i[i*AW +: AW];
            sel_wdata = bus.mst_wdata_i[i*DW +: DW];
            sel_we    = bus.mst_we_i[i];
         end
      end
   end

`ifdef MM_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] tmo_cnt_q;
   logic       tmo_q;

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   // counter sits at 0 outside HOLD, so every HOLD entry starts fresh
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_q     <= (st_q == ST_HOLD) && own_lock
                      && !own_req && tmo_hit;
         tmo_cnt_q <= (st_q == ST_HOLD) ?
                      tmo_cnt_q + 8'd1 : 8'd0;
      end
   end

   assign bus.arb_tmo_o = tmo_q;
`else
   logic unused_tmo;

   assign unused_tmo    = ^8'(TIMEOUT_CYC);
   assign tmo_hit       = 1'b0;
   assign bus.arb_tmo_o = 1'b0;
`endif

   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) st_q <= ST_IDLE;
      else          st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      load = 1'b0;
      drop = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (win_vld) begin
               st_d = ST_XFER;
               load = 1'b1;
            end
         end
         ST_XFER: st_d = ST_ACK;
         ST_ACK: begin
            if (own_lock) begin
               st_d = ST_HOLD;
            end else begin
               st_d = ST_IDLE;
               drop = 1'b1;
            end
         end
         ST_HOLD: begin
            // a new request beats a lock release
            if (own_req) begin
               st_d = ST_XFER;
               load = 1'b1;
            end else if (!own_lock || tmo_hit) begin
               st_d = ST_IDLE;
               drop = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         gnt_q   <= '0;
         last_q  <= {1'b1, {(N-1){1'b0}}};
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (load) begin
            gnt_q   <= sel;
            last_q  <= sel;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
         end
         if (drop) gnt_q <= '0;
         if (st_q == ST_XFER) rdata_q <= bus.mm_m_rdata_i;
      end
   end

   // bus is forced idle outside XFER so each write is a single strobe
   always_comb begin
      bus.mm_m_addr_o  = '0;
      bus.mm_m_wdata_o = '0;
      bus.mm_m_we_o    = 1'b0;
      bus.mst_ack_o    = '0;
      bus.mst_gnt_o    = gnt_q;
      bus.mst_rdata_o  = rdata_q;
      if (st_q == ST_XFER) begin
         bus.mm_m_addr_o  = addr_q;
         bus.mm_m_wdata_o = wdata_q;
         bus.mm_m_we_o    = we_q;
      end
      if (st_q == ST_ACK) bus.mst_ack_o = gnt_q;
   end

endmodule
